hazard_unit: RTL

Pipeline hazard controller for the Osiris I 5-stage RV32I core; the producer side of the execute-stage forwarding selects. It keeps its own shadow copy of the register-address and control pipeline for the EX, MEM and WB stages. From that copy it drives the rs1/rs2 forwarding selects consumed by the execute stage, plus all stall and flush strobes. It also counts load-use stalls and control-flow flushes for performance monitoring.

---
 rtl/hazard_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - 5-stage RV32I hazard controller: forwarding selects, stall/flush strobes, perf counters.
// Keeps a shadow EX/MEM/WB copy of register addresses and write/load controls.
module hazard_unit #(
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ADDR_WIDTH-1:0]  i_rs1_D,
  input  logic [ADDR_WIDTH-1:0]  i_rs2_D,
  input  logic [ADDR_WIDTH-1:0]  i_rd_D,
  input  logic                   i_reg_write_D,
  input  logic [1:0]             i_result_src_D,
  input  logic                   i_pc_src_EX,
  input  logic                   i_dmem_wait,
  output logic [1:0]             o_forward_rs1_EX,
  output logic [1:0]             o_forward_rs2_EX,
  output logic                   o_stall_F,
  output logic                   o_stall_D,
  output logic                   o_stall_E,
  output logic                   o_stall_M,
  output logic                   o_flush_D,
  output logic                   o_flush_E,
  output logic                   o_flush_W,
  output logic [COUNT_WIDTH-1:0] o_lw_stall_cnt,
  output logic [COUNT_WIDTH-1:0] o_flush_cnt
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic                  reg_write_e, load_e, reg_write_m, reg_write_w;
  logic                  lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] src,
                                         input logic [ADDR_WIDTH-1:0] rdm,
                                         input logic                  rwm,
                                         input logic [ADDR_WIDTH-1:0] rdw,
                                         input logic                  rww);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (rwm && rdm == src)      sel = 2'b10;
      else if (rww && rdw == src) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lw_stall = load_e && (rd_e != '0) && ((rd_e == i_rs1_D) || (rd_e == i_rs2_D));
    o_forward_rs1_EX = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    o_forward_rs2_EX = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    // A resolved branch overrides a load-use stall so the target gets fetched.
    o_stall_F = (lw_stall && !i_pc_src_EX) || i_dmem_wait;
    o_stall_D = o_stall_F;
    o_stall_E = i_dmem_wait;
    o_stall_M = i_dmem_wait;
    o_flush_W = i_dmem_wait;
    o_flush_D = i_pc_src_EX && !i_dmem_wait;
    o_flush_E = (lw_stall || i_pc_src_EX) && !i_dmem_wait;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs1_e          <= '0;
      rs2_e          <= '0;
      rd_e           <= '0;
      reg_write_e    <= 1'b0;
      load_e         <= 1'b0;
      rd_m           <= '0;
      reg_write_m    <= 1'b0;
      rd_w           <= '0;
      reg_write_w    <= 1'b0;
      o_lw_stall_cnt <= '0;
      o_flush_cnt    <= '0;
    end else begin
      if (!o_stall_E) begin
        if (o_flush_E) begin
          rs1_e       <= '0;
          rs2_e       <= '0;
          rd_e        <= '0;
          reg_write_e <= 1'b0;
          load_e      <= 1'b0;
        end else begin
          rs1_e       <= i_rs1_D;
          rs2_e       <= i_rs2_D;
          rd_e        <= i_rd_D;
          reg_write_e <= i_reg_write_D;
          load_e      <= (i_result_src_D == 2'b01);
        end
      end
      if (!o_stall_M) begin
        rd_m        <= rd_e;
        reg_write_m <= reg_write_e;
      end
      if (o_flush_W) begin
        rd_w        <= '0;
        reg_write_w <= 1'b0;
      end else begin
        rd_w        <= rd_m;
        reg_write_w <= reg_write_m;
      end
      // Performance counters stick at all-ones rather than wrapping.
      if (lw_stall && !i_dmem_wait && o_lw_stall_cnt != CNT_MAX)
        o_lw_stall_cnt <= o_lw_stall_cnt + CNT_ONE;
      if (o_flush_D && o_flush_cnt != CNT_MAX)
        o_flush_cnt <= o_flush_cnt + CNT_ONE;
    end
  end

endmodule
